// File: rtl/rot_pkg.sv
// rot_pkg: shared constants, FSM states and fixed-point helpers for the rotation sequencer
package rot_pkg;
  localparam int FRAC = 12;
  localparam int W = 16;
  localparam logic [W-1:0] ONE = 16'h1000;
  localparam logic [W-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [W-1:0] SAT_MIN = 16'h8000;
  typedef enum logic [1:0] {IDLE, MUL1, MUL2, DONE} state_t;
  typedef enum logic [1:0] {AX_Z, AX_Y, AX_X} axis_t;
  function automatic logic [W-1:0] sat_neg(input logic [W-1:0] v);
    return v == SAT_MIN ? SAT_MAX : -v;
  endfunction
  // Round half up at the binary point, then clamp to the W-bit signed range.
  function automatic logic [W-1:0] round_sat(input logic signed [33:0] acc);
    logic signed [33:0] r;
    r = (acc + 34'(1 << (FRAC - 1))) >>> FRAC;
    return r > 34'sd32767 ? SAT_MAX : (r < -34'sd32768 ? SAT_MIN : r[W-1:0]);
  endfunction
endpackage

// File: rtl/rot_elem_matrix.sv
// rot_elem_matrix: elementary single-axis rotation matrix from cos/sin
//   i_axis  axis select (AX_Z, AX_Y, AX_X)
//   i_c     cosine, Q3.12
//   i_s     sine, Q3.12
//   o_e     9 entries, row-major, entry r*3+c at bits [(r*3+c)*W +: W]
module rot_elem_matrix import rot_pkg::*; (
  input  logic [1:0]     i_axis,
  input  logic [W-1:0]   i_c,
  input  logic [W-1:0]   i_s,
  output logic [9*W-1:0] o_e
);
  logic [W-1:0] w_ns, w_zero;
  logic w_z, w_y, w_x;
  assign w_ns = sat_neg(i_s);
  assign w_zero = '0;
  assign w_z = i_axis == AX_Z;
  assign w_y = i_axis == AX_Y;
  assign w_x = i_axis == AX_X;
  assign o_e = {
    w_z ? ONE  : i_c,
    w_x ? i_s  : w_zero,
    w_y ? w_ns : w_zero,
    w_x ? w_ns : w_zero,
    w_y ? ONE  : i_c,
    w_z ? i_s  : w_zero,
    w_y ? i_s  : w_zero,
    w_z ? w_ns : w_zero,
    w_x ? ONE  : i_c
  };
endmodule

// File: rtl/rot_compose_seq.sv
// rot_compose_seq: builds R = Rz*Ry*Rx in Q3.12 with one time-shared MAC
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   angle-set handshake (cos1/sin1 z, cos2/sin2 y, cos3/sin3 x)
//   busy                high while multiplying
//   out_valid/out_ready result handshake, m11..m33 registered result
module rot_compose_seq import rot_pkg::*; (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] cos1,
  input  logic [W-1:0] sin1,
  input  logic [W-1:0] cos2,
  input  logic [W-1:0] sin2,
  input  logic [W-1:0] cos3,
  input  logic [W-1:0] sin3,
  output logic         busy,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] m11, m12, m13,
  output logic [W-1:0] m21, m22, m23,
  output logic [W-1:0] m31, m32, m33
);
  state_t r_state;
  logic [1:0] r_i, r_j, r_k;
  logic signed [33:0] r_acc;
  logic [W-1:0] r_c1, r_s1, r_c2, r_s2, r_c3, r_s3;
  logic [W-1:0] r_mm [9];
  logic [W-1:0] r_m [9];
  logic [9*W-1:0] w_rz, w_ry, w_rx;
  logic [3:0] w_aidx, w_bidx, w_oidx;
  logic signed [W-1:0] w_a, w_b;
  logic signed [31:0] w_prod;
  logic signed [33:0] w_sum;
  logic w_kend, w_last;
  rot_elem_matrix u_rz (.i_axis(AX_Z), .i_c(r_c1), .i_s(r_s1), .o_e(w_rz));
  rot_elem_matrix u_ry (.i_axis(AX_Y), .i_c(r_c2), .i_s(r_s2), .o_e(w_ry));
  rot_elem_matrix u_rx (.i_axis(AX_X), .i_c(r_c3), .i_s(r_s3), .o_e(w_rx));
  assign w_aidx = {2'b0, r_i} * 4'd3 + {2'b0, r_k};
  assign w_bidx = {2'b0, r_k} * 4'd3 + {2'b0, r_j};
  assign w_oidx = {2'b0, r_i} * 4'd3 + {2'b0, r_j};
  // MUL1 multiplies Rz*Ry; MUL2 multiplies the stored M by Rx.
  assign w_a = r_state == MUL2 ? r_mm[w_aidx] : w_rz[w_aidx*W +: W];
  assign w_b = r_state == MUL2 ? w_rx[w_bidx*W +: W] : w_ry[w_bidx*W +: W];
  assign w_prod = 32'(w_a) * 32'(w_b);
  assign w_sum = (r_k == 2'd0 ? 34'sd0 : r_acc) + 34'(w_prod);
  assign w_kend = r_k == 2'd2;
  assign w_last = w_kend && r_j == 2'd2 && r_i == 2'd2;
  assign in_ready = r_state == IDLE;
  assign busy = r_state == MUL1 || r_state == MUL2;
  assign out_valid = r_state == DONE;
  assign {m33, m32, m31, m23, m22, m21, m13, m12, m11} =
    {r_m[8], r_m[7], r_m[6], r_m[5], r_m[4], r_m[3], r_m[2], r_m[1], r_m[0]};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_i <= '0;
      r_j <= '0;
      r_k <= '0;
      r_acc <= '0;
      {r_c1, r_s1, r_c2, r_s2, r_c3, r_s3} <= '0;
      for (int n = 0; n < 9; n++) begin
        r_mm[n] <= '0;
        r_m[n] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          {r_c1, r_s1, r_c2, r_s2, r_c3, r_s3} <= {cos1, sin1, cos2, sin2, cos3, sin3};
          r_state <= MUL1;
        end
        MUL1, MUL2: begin
          r_acc <= w_sum;
          r_k <= w_kend ? 2'd0 : r_k + 2'd1;
          if (w_kend) begin
            r_j <= r_j == 2'd2 ? 2'd0 : r_j + 2'd1;
            if (r_j == 2'd2) r_i <= r_i == 2'd2 ? 2'd0 : r_i + 2'd1;
            if (r_state == MUL1) r_mm[w_oidx] <= round_sat(w_sum);
            else r_m[w_oidx] <= round_sat(w_sum);
          end
          if (w_last) r_state <= r_state == MUL1 ? MUL2 : DONE;
        end
        DONE: if (out_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rot_compose_seq.sv
// tb_rot_compose_seq: randomized and directed checks of rot_compose_seq against a matrix model
module tb_rot_compose_seq;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic in_ready, busy, out_valid;
  logic [15:0] cos1 = 0, sin1 = 0, cos2 = 0, sin2 = 0, cos3 = 0, sin3 = 0;
  logic [15:0] m11, m12, m13, m21, m22, m23, m31, m32, m33;
  logic [15:0] dm [9];
  logic [143:0] dv;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  rot_compose_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .cos1(cos1), .sin1(sin1), .cos2(cos2), .sin2(sin2), .cos3(cos3), .sin3(sin3),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .m11(m11), .m12(m12), .m13(m13), .m21(m21), .m22(m22), .m23(m23),
    .m31(m31), .m32(m32), .m33(m33)
  );
  assign dm = '{m11, m12, m13, m21, m22, m23, m31, m32, m33};
  assign dv = {m33, m32, m31, m23, m22, m21, m13, m12, m11};
  task automatic chk(input string tag, input logic [143:0] got, input logic [143:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic longint sv(input logic [15:0] v);
    return longint'($signed(v));
  endfunction
  function automatic longint ng(input logic [15:0] v);
    return v == 16'h8000 ? 64'sd32767 : -sv(v);
  endfunction
  function automatic longint rs(input longint x);
    longint y;
    y = (x + 2048) >>> 12;
    return y > 32767 ? 64'sd32767 : (y < -32768 ? -64'sd32768 : y);
  endfunction
  task automatic model(input logic [15:0] c1, s1, c2, s2, c3, s3, output logic [15:0] e [9]);
    longint a [3][3], b [3][3], x [3][3], m [3][3], s;
    a = '{'{sv(c1), ng(s1), 0}, '{sv(s1), sv(c1), 0}, '{0, 0, 4096}};
    b = '{'{sv(c2), 0, sv(s2)}, '{0, 4096, 0}, '{ng(s2), 0, sv(c2)}};
    x = '{'{4096, 0, 0}, '{0, sv(c3), ng(s3)}, '{0, sv(s3), sv(c3)}};
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        s = 0;
        for (int k = 0; k < 3; k++) s += a[i][k] * b[k][j];
        m[i][j] = rs(s);
      end
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        s = 0;
        for (int k = 0; k < 3; k++) s += m[i][k] * x[k][j];
        e[i*3+j] = 16'(rs(s));
      end
  endtask
  task automatic run_txn(input logic [15:0] c1, s1, c2, s2, c3, s3, input bit pulse, input bit hold);
    logic [15:0] e [9];
    logic [143:0] ev;
    int n;
    model(c1, s1, c2, s2, c3, s3, e);
    ev = {e[8], e[7], e[6], e[5], e[4], e[3], e[2], e[1], e[0]};
    chk("in_ready_idle", 144'(in_ready), 144'(1));
    {cos1, sin1, cos2, sin2, cos3, sin3} = {c1, s1, c2, s2, c3, s3};
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    {cos1, sin1, cos2, sin2, cos3, sin3} = {$urandom, $urandom, $urandom};
    chk("busy_after_accept", 144'({busy, in_ready}), 144'(2'b10));
    n = 0;
    while (!out_valid && n < 200) begin
      in_valid = pulse && n >= 2 && n < 6;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 0;
    chk("latency", 144'(n), 144'(54));
    chk("busy_done", 144'({busy, in_ready}), 144'(0));
    for (int k = 0; k < 9; k++) chk($sformatf("m%0d%0d", k / 3 + 1, k % 3 + 1), 144'(dm[k]), 144'(e[k]));
    if (hold)
      repeat (10) begin
        @(posedge clk); #1;
        chk("hold_valid", 144'({out_valid, in_ready}), 144'(2'b10));
        chk("hold_m", dv, ev);
      end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("release", 144'({out_valid, in_ready}), 144'(2'b01));
  endtask
  initial begin
    #1;
    chk("rst_flags", 144'({in_ready, out_valid, busy}), 144'(3'b100));
    chk("rst_m", dv, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    run_txn(16'h1000, 0, 16'h1000, 0, 16'h1000, 0, 0, 1);
    run_txn(0, 16'h1000, 16'h1000, 0, 16'h1000, 0, 1, 0);
    run_txn(0, 16'h1000, 0, 16'h1000, 0, 16'h1000, 0, 0);
    run_txn(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h1000, 0, 0, 0);
    run_txn(16'h1000, 16'h8000, 16'h1000, 0, 16'h1000, 0, 0, 0);
    run_txn(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 0, 0);
    repeat (8) run_txn($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 1, 0);
    repeat (4) run_txn($urandom_range(16'h1000) - 16'h0800, $urandom_range(16'h1000) - 16'h0800,
                       $urandom_range(16'h1000) - 16'h0800, $urandom_range(16'h1000) - 16'h0800,
                       $urandom_range(16'h1000) - 16'h0800, $urandom_range(16'h1000) - 16'h0800, 0, 0);
    {cos1, sin1, cos2, sin2, cos3, sin3} = {$urandom, $urandom, $urandom};
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (19) @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("abort_flags", 144'({in_ready, out_valid, busy}), 144'(3'b100));
    chk("abort_m", dv, '0);
    #3 rst_n = 1;
    @(posedge clk); #1;
    run_txn(0, 16'h1000, 16'h1000, 0, 16'h1000, 0, 0, 0);
    run_txn($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
